// File: rtl/exe_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with start/done handshake, stall request and flush.
// Multiply spends MUL_LATENCY cycles; divide is radix-2 restoring over operand magnitudes.
module exe_muldiv #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stallreq_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t state_q, state_d;

  logic              accept;
  logic              div_signed, neg_a, neg_b;
  logic              div_zero, div_ovf, special;
  logic              mul_last, div_last;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN-1:0]   opa_p1, opb_p1, rem_p1;
  logic [1:0]        f3_p1;
  logic [4:0]        rd_p1;
  logic              qneg_p1, rneg_p1;

  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   rem_nx, quo_nx;
  logic [XLEN-1:0]   div_res, mul_res;
  logic              mul_sa, mul_sb;
  logic signed [2*XLEN-1:0] ma_p0, mb_p0, prod_p0;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Divide-by-zero and signed-overflow results resolve without iterating.
  function automatic logic [XLEN-1:0] special_res(input logic is_rem, input logic zero_div,
                                                 input logic [XLEN-1:0] dividend);
    if (zero_div) return is_rem ? dividend : '1;
    return is_rem ? '0 : dividend;
  endfunction

  assign accept     = (state_q == S_IDLE) & start_i & ~flush_i;
  assign div_signed = ~funct3_i[0];
  assign neg_a      = div_signed & rs1_i[XLEN-1];
  assign neg_b      = div_signed & rs2_i[XLEN-1];
  assign div_zero   = (rs2_i == '0);
  assign div_ovf    = div_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  assign special    = funct3_i[2] & (div_zero | div_ovf);
  assign mul_last   = (cnt_q == CNT_W'(MUL_LATENCY - 1));
  assign div_last   = (cnt_q == CNT_W'(XLEN - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = !funct3_i[2] ? S_MUL : (special ? S_FIN : S_DIV);
      S_MUL:  if (flush_i) state_d = S_IDLE; else if (mul_last) state_d = S_FIN;
      S_DIV:  if (flush_i) state_d = S_IDLE; else if (div_last) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o     = (state_q == S_MUL) | (state_q == S_DIV);
    done_o     = (state_q == S_FIN);
    stallreq_o = ~rst_i & (accept | (state_q == S_MUL) | (state_q == S_DIV));
  end

  // Stage p0: one restoring-division step and the extended-operand product
  always_comb begin
    rem_sh  = {rem_p1, opa_p1[XLEN-1]};
    diff    = rem_sh - {1'b0, opb_p1};
    rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx  = {opa_p1[XLEN-2:0], ~diff[XLEN]};
    div_res = f3_p1[1] ? cond_neg(rem_nx, rneg_p1) : cond_neg(quo_nx, qneg_p1);
    mul_sa  = (f3_p1 != 2'b11);
    mul_sb  = ~f3_p1[1];
    ma_p0   = $signed({{XLEN{mul_sa & opa_p1[XLEN-1]}}, opa_p1});
    mb_p0   = $signed({{XLEN{mul_sb & opb_p1[XLEN-1]}}, opb_p1});
    prod_p0 = ma_p0 * mb_p0;
    mul_res = (f3_p1 == 2'b00) ? prod_p0[XLEN-1:0] : prod_p0[2*XLEN-1:XLEN];
  end

  // Stage p1: operand capture at accept, iteration state while busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (busy_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      f3_p1   <= funct3_i[1:0];
      rd_p1   <= rd_addr_i;
      rem_p1  <= '0;
      qneg_p1 <= neg_a ^ neg_b;
      rneg_p1 <= neg_a;
      opa_p1  <= funct3_i[2] ? cond_neg(rs1_i, neg_a) : rs1_i;
      opb_p1  <= funct3_i[2] ? cond_neg(rs2_i, neg_b) : rs2_i;
    end else if (state_q == S_DIV) begin
      opa_p1  <= quo_nx;
      rem_p1  <= rem_nx;
    end
  end

  // Output stage: result and tag registered on completion, held until the next one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept && special) begin
      result_o  <= special_res(funct3_i[1], div_zero, rs1_i);
      rd_addr_o <= rd_addr_i;
    end else if (state_q == S_MUL && mul_last && !flush_i) begin
      result_o  <= mul_res;
      rd_addr_o <= rd_p1;
    end else if (state_q == S_DIV && div_last && !flush_i) begin
      result_o  <= div_res;
      rd_addr_o <= rd_p1;
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Randomised and directed bench for exe_muldiv at XLEN=32 and XLEN=64 against an arithmetic model.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, st32, st64;
  logic [2:0]  f3;
  logic [4:0]  rdin;
  logic [31:0] a32, b32;
  logic [63:0] a64, b64;

  logic        busy32, stall32, done32, busy64, stall64, done64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  rdo32, rdo64;

  int checks = 0;
  int errors = 0;

  exe_muldiv #(.XLEN(32), .MUL_LATENCY(2)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(st32), .funct3_i(f3), .rs1_i(a32), .rs2_i(b32),
    .rd_addr_i(rdin), .flush_i(flush), .busy_o(busy32), .stallreq_o(stall32),
    .done_o(done32), .result_o(res32), .rd_addr_o(rdo32));

  exe_muldiv #(.XLEN(64), .MUL_LATENCY(2)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(st64), .funct3_i(f3), .rs1_i(a64), .rs2_i(b64),
    .rd_addr_i(rdin), .flush_i(flush), .busy_o(busy64), .stallreq_o(stall64),
    .done_o(done64), .result_o(res64), .rd_addr_o(rdo64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide signed/unsigned arithmetic on the architectural operands.
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] f,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, r;
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (w == 64) begin
      sa = {{64{a[63]}}, a};  sb = {{64{b[63]}}, b};
      ua = {64'b0, a};        ub = {64'b0, b};
    end else begin
      sa = {{96{a[31]}}, a[31:0]};  sb = {{96{b[31]}}, b[31:0]};
      ua = {96'b0, a[31:0]};        ub = {96'b0, b[31:0]};
    end
    case (f)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: r = (ub == 0) ? -128'sd1 : sa / sb;
      3'd5: r = (ub == 0) ? -128'sd1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic int exp_latency(input int w, input logic [2:0] f,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (!f[2]) return 2;
    if ((b & mask) == 0) return 0;
    if (!f[0] && (a & mask) == minv && (b & mask) == mask) return 0;
    return w;
  endfunction

  function automatic logic sel_done(input bit wide);  return wide ? done64  : done32;  endfunction
  function automatic logic sel_busy(input bit wide);  return wide ? busy64  : busy32;  endfunction
  function automatic logic sel_stall(input bit wide); return wide ? stall64 : stall32; endfunction

  task automatic run_op(input bit wide, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
    int w, lat, n;
    bit bad;
    logic [63:0] exp;
    w   = wide ? 64 : 32;
    exp = ref_op(w, f, a, b);
    lat = exp_latency(w, f, a, b);
    @(negedge clk);
    f3 = f; rdin = rd;
    if (wide) begin st64 = 1'b1; a64 = a; b64 = b; end
    else      begin st32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; end
    #1;
    check("stall_accept", 64'(sel_stall(wide)), 64'd1);
    @(negedge clk);
    st32 = 1'b0; st64 = 1'b0;
    n = 0; bad = 0;
    while (!sel_done(wide) && n < w + 8) begin
      if (!sel_busy(wide) || !sel_stall(wide)) bad = 1;
      @(negedge clk);
      n++;
    end
    check($sformatf("latency f%0d", f), 64'(n), 64'(lat));
    check($sformatf("result f%0d %h %h", f, a, b), wide ? res64 : {32'b0, res32}, exp);
    check("rd_tag", 64'(wide ? rdo64 : rdo32), 64'(rd));
    check("busy_stall_during", 64'(bad), 64'd0);
    check("fin_stall", 64'(sel_stall(wide)), 64'd0);
    check("fin_busy", 64'(sel_busy(wide)), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(sel_done(wide)), 64'd0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(1, 50));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [31:0] prev;
    int seen;
    rst = 1'b1; flush = 1'b0; st32 = 1'b0; st64 = 1'b0;
    f3 = '0; rdin = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_stall", 64'(stall32), 64'd0);
    check("rst_result", 64'(res32), 64'd0);
    check("rst_rd", 64'(rdo32), 64'd0);
    rst = 1'b0;

    run_op(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd5);
    run_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 5'd6);
    run_op(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7);
    run_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd8);
    run_op(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd9);
    run_op(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd10);
    run_op(0, 3'd5, 64'd5, 64'd0, 5'd11);
    run_op(0, 3'd6, 64'd5, 64'd0, 5'd12);
    run_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13);
    run_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd14);

    // Flush a divide ten edges after accept.
    prev = res32;
    @(negedge clk);
    f3 = 3'd4; a32 = 32'd100; b32 = 32'd7; rdin = 5'd3; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_done", 64'(done32), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hold", 64'(res32), 64'(prev));
    run_op(0, 3'd0, 64'd123, 64'd456, 5'd17);

    // Same abort through reset.
    @(negedge clk);
    f3 = 3'd5; a32 = 32'd1000; b32 = 32'd9; rdin = 5'd4; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rrst_busy", 64'(busy32), 64'd0);
    check("rrst_done", 64'(done32), 64'd0);
    check("rrst_stall", 64'(stall32), 64'd0);
    check("rrst_result", 64'(res32), 64'd0);
    check("rrst_rd", 64'(rdo32), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    check("rrst_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 150; i++)
      run_op(0, 3'($urandom_range(0, 7)), {32'b0, pick32()}, {32'b0, pick32()},
             5'($urandom_range(0, 31)));

    run_op(1, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 5'd20);
    run_op(1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21);
    for (int i = 0; i < 40; i++)
      run_op(1, 3'($urandom_range(0, 7)), pick64(), pick64(), 5'($urandom_range(0, 31)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
